// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract unit: one full adder reused LSB-first across WIDTH clocks,
// with carry held in a flop and carry/overflow/zero flags captured on the last bit.

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cIn,
  output logic sum,
  output logic cOut
);
  assign sum  = in1 ^ in2 ^ cIn;
  assign cOut = (in1 & in2) | (cIn & (in1 ^ in2));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cOut,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               last_bit_s;
  logic               fa_sum_s;
  logic               fa_cout_s;

  full_adder u_fa (
    .in1  (sh_a_q[0]),
    .in2  (sh_b_q[0]),
    .cIn  (carry_q),
    .sum  (fa_sum_s),
    .cOut (fa_cout_s)
  );

  // A start is only honoured outside RUN, so DONE can chain directly into the next op.
  assign accept_s   = start && (state_q != ST_RUN);
  assign last_bit_s = (state_q == ST_RUN) && (count_q == LAST_CNT);

  // Control FSM next-state and registered handshake flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN; else state_d = ST_IDLE;
      ST_RUN:  if (last_bit_s) state_d = ST_DONE; else state_d = ST_RUN;
      ST_DONE: if (start) state_d = ST_RUN; else state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Datapath: operand capture on accept, one bit per clock in RUN, flags on the last bit.
  always_comb begin
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    result_d = result_q;
    count_d  = count_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (accept_s) begin
      // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
      sh_a_d   = opA;
      sh_b_d   = sub ? ~opB : opB;
      carry_d  = sub;
      count_d  = {CNT_W{1'b0}};
      result_d = {WIDTH{1'b0}};
    end else if (state_q == ST_RUN) begin
      sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
      sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
      result_d = {fa_sum_s, result_q[WIDTH-1:1]};
      carry_d  = fa_cout_s;
      count_d  = count_q + CNT_ONE;
      if (last_bit_s) begin
        c_out_d = fa_cout_s;
        ovf_d   = carry_q ^ fa_cout_s;
        zero_d  = !fa_sum_s && (result_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
      end else begin
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= {WIDTH{1'b0}};
      sh_b_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      result_q <= result_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cOut     = c_out_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed and random add/subtract against
// an arithmetic reference, plus ignored-start, back-to-back and mid-run reset scenarios.

module tb_bit_serial_adder;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        sub;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cOut;
  logic        overflow;
  logic        zero;

  int tests = 0;
  int fails = 0;

  bit_serial_adder #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .start    (start),
    .sub      (sub),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cOut     (cOut),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference: {result, cOut, overflow, zero} from plain 33-bit arithmetic and sign rules.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] full;
    logic [31:0] r;
    logic        o;
    if (s) full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    else   full = {1'b0, a} + {1'b0, b};
    r = full[31:0];
    if (s) o = (a[31] != b[31]) && (r[31] != a[31]);
    else   o = (a[31] == b[31]) && (r[31] != a[31]);
    return {r, full[32], o, (r == 32'd0)};
  endfunction

  // Launch one op and wait (bounded) for done; returns outputs seen in the done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [34:0] got, output int lat, output int busy_cnt);
    @(negedge clk);
    opA = a; opB = b; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opA = $urandom; opB = $urandom; sub = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    got = {result, cOut, overflow, zero};
  endtask

  task automatic test_reset;
    resetN = 1'b0; start = 1'b0; sub = 1'b0; opA = 32'd0; opB = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, result, cOut, overflow, zero} !== 37'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h c=%b o=%b z=%b, expected all 0",
               busy, done, result, cOut, overflow, zero);
    end
    resetN = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] av [8] = '{32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd3, 32'd0, 32'h80000000};
    logic [31:0] bv [8] = '{32'd3, 32'h00000001, 32'h00000001, 32'h00000001, 32'd5, 32'd5, 32'd0, 32'h80000000};
    logic        sv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [34:0] got, exp;
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      do_op(av[i], bv[i], sv[i], got, lat, bc);
      exp = model(av[i], bv[i], sv[i]);
      tests++;
      if (got !== exp || lat != 32 || bc != 32) begin
        fails++;
        $display("FAIL directed_%0d: got {res,c,o,z}=%h lat=%0d busy=%0d, expected %h lat=32 busy=32",
                 i, got, lat, bc, exp);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse_%0d: got done=%b busy=%b after done cycle, expected 0 0", i, done, busy);
      end
    end
    // Spot-check the model itself against hand-derived spec values.
    exp = model(32'd3, 32'd5, 1'b1);
    tests++;
    if (exp !== {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL model_3_minus_5: got %h, expected fffffffe/c0/o0/z0", exp);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    logic [34:0] got, exp;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 5 == 0) b = a;
      do_op(a, b, s, got, lat, bc);
      exp = model(a, b, s);
      tests++;
      if (got !== exp || lat != 32) begin
        fails++;
        $display("FAIL random_%0d: a=%h b=%h sub=%b got %h lat=%0d, expected %h lat=32", i, a, b, s, got, lat, exp);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [34:0] exp;
    int lat;
    @(negedge clk);
    opA = 32'h00000100; opB = 32'h00000023; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    opA = 32'hDEADBEEF; opB = 32'h12345678; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 11;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp = model(32'h00000100, 32'h00000023, 1'b0);
    tests++;
    if ({result, cOut, overflow, zero} !== exp || lat != 32) begin
      fails++;
      $display("FAIL ignored_start: got %h lat=%0d, expected %h lat=32", {result, cOut, overflow, zero}, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [34:0] exp1, exp2;
    int lat;
    @(negedge clk);
    opA = 32'h12345678; opB = 32'h11111111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opA = 32'h00000010; opB = 32'h00000020; sub = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp1 = model(32'h12345678, 32'h11111111, 1'b0);
    tests++;
    if ({result, cOut, overflow, zero} !== exp1 || lat != 32) begin
      fails++;
      $display("FAIL b2b_first: got %h lat=%0d, expected %h lat=32", {result, cOut, overflow, zero}, lat, exp1);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp2 = model(32'h00000010, 32'h00000020, 1'b1);
    tests++;
    if ({result, cOut, overflow, zero} !== exp2 || lat != 32) begin
      fails++;
      $display("FAIL b2b_second: got %h lat=%0d, expected %h lat=32", {result, cOut, overflow, zero}, lat, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    logic [34:0] got, exp;
    int lat, bc;
    bit saw_done;
    @(negedge clk);
    opA = 32'hFFFF0000; opB = 32'h0000FFFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    tests++;
    if ({busy, done, result, cOut, overflow, zero} !== 37'd0) begin
      fails++;
      $display("FAIL midop_reset: got busy=%b done=%b result=%h c=%b o=%b z=%b, expected all 0",
               busy, done, result, cOut, overflow, zero);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL midop_no_done: got done/busy activity after reset, expected none");
    end
    do_op(32'd5, 32'd3, 1'b0, got, lat, bc);
    exp = {32'd8, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== exp || lat != 32) begin
      fails++;
      $display("FAIL after_reset_5p3: got %h lat=%0d, expected %h lat=32", got, lat, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
Bit-serial add/subtract unit for the 32-bit ALU. It drives a single FullAdder instance one bit per clock, LSB first, and holds the carry in a flip-flop between bits. It collects the sum bits into a result register and produces carry, overflow and zero flags. Its role is the area-minimal arithmetic path, with a start/busy/done handshake toward the ALU control.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 2)
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
resetN  input  1  synchronous, active-low reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = A+B, 1 = A-B; sampled with start
opA  input  WIDTH  operand A; sampled with start
opB  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse when result/flags become valid
result  output  WIDTH  sum/difference; held until next accepted start
cOut  output  1  carry out of MSB (for subtract: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- One clock; reset is synchronous and active-low (resetN sampled on rising clk).
- Reset (resetN=0 at an edge): state=IDLE; busy=0, done=0, result=0, cOut=0, overflow=0, zero=0; shift registers, carry FF and counter cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> RUN while count < WIDTH-1.
  - RUN -> DONE at the edge that processes bit WIDTH-1.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Accept (edge where start=1 and state is IDLE or DONE):
  - shA <= opA; shB <= sub ? ~opB : opB; carry <= sub; count <= 0.
  - The result register is cleared to 0 at accept.
- RUN, each edge:
  - FullAdder inputs are in1=shA[0], in2=shB[0], cIn=carry.
  - Update: carry <= fa.cOut; result <= {fa.sum, result[WIDTH-1:1]}; shA and shB shift right one bit; count++.
- Last bit (count = WIDTH-1):
  - cOut <= fa.cOut.
  - overflow <= carry XOR fa.cOut, i.e. carry into MSB XOR carry out of MSB.
  - zero <= (fa.sum==0) AND (result[WIDTH-1:1]==0).
- Latency: accept at edge k; done=1 and flags valid during the cycle after edge k+WIDTH. With WIDTH=32, done rises exactly 32 clocks after the accept edge.
- busy=1 exactly in RUN. done=1 exactly in DONE, so it is a one-cycle pulse.
- start while busy=1 is ignored: no queueing, no operand capture, in-flight operation unaffected.
- start asserted during the DONE cycle is accepted. done is still 1 in that cycle; busy goes to 1 at the next edge.
- opA, opB and sub may change freely after accept; only the captured copies are used.
- result, cOut, overflow and zero change only at accept (result cleared, flags held), during RUN shifting (result), or at the last bit (flags). Consumers read them only when done=1.

Test Plan:
- Reset, then opA=5, opB=3, sub=0, start 1 cycle -> busy for 32 cycles; done pulse with result=0x00000008, cOut=0, overflow=0, zero=0.
- opA=0xFFFFFFFF, opB=0x00000001, sub=0 -> result=0x00000000, cOut=1, overflow=0, zero=1.
- opA=0x7FFFFFFF, opB=0x00000001, sub=0 -> result=0x80000000, cOut=0, overflow=1, zero=0. Also opA=0x80000000, opB=0x00000001, sub=1 -> result=0x7FFFFFFF, overflow=1, cOut=1.
- Subtract cases:
  - opA=5, opB=5, sub=1 -> result=0, cOut=1, zero=1.
  - opA=3, opB=5, sub=1 -> result=0xFFFFFFFE, cOut=0, overflow=0.
- Pulse start again at cycle 10 of a run with different operands -> ignored; first result unchanged. Start held high through the DONE cycle -> new operation accepted back-to-back, and its done arrives 32 clocks later.
- Drop resetN for 1 cycle at bit 17 -> all outputs 0, state IDLE, no done pulse. A following 5+3 completes correctly with result 8.
